syzygy_adc_capture: RTL
=======================

# syzygy_adc_capture

Capture buffer for the SYZYGY ADC path, the receive-side counterpart of the DAC playback buffer. It takes deserialized 12-bit ADC samples, waits for an arm command and an optional level trigger, and writes a fixed-length record into an internal dual-port RAM. The FFT/host side then reads the record back through a synchronous read port. It sits between the ADC PHY/SPI controller and the FFT front end.

## Interface
- DEPTH_LOG2, 10, log2 of record length (1024 samples)
- DATA_W, 12, sample width; samples are two's complement
- clk  in  1  sample clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- adc_data_i  in  DATA_W  sample from ADC PHY
- adc_valid  in  1  adc_data_i valid this cycle
- adc_ready  in  1  ADC SPI init complete; required for capture
- arm  in  1  start request, sampled each cycle
- trig_en  in  1  0 = free-run start, 1 = level trigger
- trig_level  in  DATA_W  signed trigger threshold
- rd_addr  in  DEPTH_LOG2  read address
- rd_en  in  1  read strobe
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data valid
- busy  out  1  state is ARMED or CAPTURE
- capture_done  out  1  full record stored
- capture_abort  out  1  one-cycle pulse on abort
- wr_count  out  DEPTH_LOG2+1  samples written in current record

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. Reset -> IDLE.
- IDLE or DONE, arm=1 -> ARMED; clears capture_done, wr_count=0, invalidates prev-sample register.
- arm ignored in ARMED and CAPTURE.
- ARMED, trig_en=0: first cycle with adc_valid && adc_ready writes sample to addr 0 -> CAPTURE, wr_count=1.
- ARMED, trig_en=1: on each adc_valid, prev-sample register updated. Trigger when prev valid, prev < trig_level and current >= trig_level (signed). Triggering sample written to addr 0 -> CAPTURE. First sample after arm never triggers.
- CAPTURE: each adc_valid writes adc_data_i at addr wr_count[DEPTH_LOG2-1:0], wr_count++. adc_valid=0 cycles skipped, no write.
- Write to addr 2^DEPTH_LOG2-1 -> DONE; wr_count = 2^DEPTH_LOG2; no further writes.
- DONE: capture_done=1, holds until next arm or reset.
- adc_ready=0 while ARMED or CAPTURE -> IDLE, capture_abort pulses 1 cycle, capture_done stays 0, wr_count holds value at abort.
- Read port independent of state; reads during CAPTURE return RAM contents (old or new, address-dependent); only DONE contents are guaranteed.
- RAM contents not reset; read before first capture returns undefined data.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=0, capture_done=0, capture_abort=0, wr_count=0.
- arm high at edge N -> busy=1 after edge N.
- Triggering/first sample at edge M -> RAM write at edge M, state CAPTURE after edge M.
- Last write at edge K -> capture_done=1, busy=0 after edge K.
- Read latency 1: rd_en high with rd_addr A at edge N -> rd_data=RAM[A], rd_valid=1 after edge N; rd_valid=0 after an edge with rd_en=0; rd_data holds last value.
- Simultaneous read and write same address: rd_data returns old contents (read-first).
- Abort and last write same cycle: abort wins; -> IDLE, capture_done=0.
- reset_n low mid-capture: immediately IDLE, all outputs to reset values.

## Test plan
- trig_en=0, adc_ready=1, ramp 0..1023 with adc_valid=1 every cycle, arm pulse -> capture_done after 1024 valid samples; read addr 0..1023 returns 0..1023, rd_valid one cycle after rd_en.
- adc_valid toggling 1/0, ramp on valid cycles only -> RAM holds contiguous ramp, wr_count increments only on valid cycles, done after 1024 valid.
- trig_en=1, trig_level=100, input sine crossing ±2000 -> addr 0 holds first sample >=100 whose predecessor <100; first post-arm sample at 500 does not trigger.
- adc_ready deasserted at sample 300 of capture -> capture_abort one-cycle pulse, busy=0, capture_done=0, wr_count=300; re-arm succeeds.
- arm pulsed during CAPTURE -> ignored, record completes unchanged; arm in DONE clears capture_done next cycle.
- reset_n asserted asynchronously mid-capture -> all outputs zero before next clock edge, state IDLE.

Source files
------------

// File: rtl/syzygy_adc_capture.sv
// -----------------------------------------------------------------------------
// syzygy_adc_capture
//
// Capture buffer for the SYZYGY ADC receive path. Waits for an arm command,
// optionally for a rising level crossing, and then stores a fixed-length
// record of samples into an internal dual-port RAM. The FFT/host side reads
// the record back through a registered, read-first read port.
//
// Ports
//   clk            sample clock, all logic on the rising edge
//   reset_n        asynchronous active-low reset
//   adc_data_i     two's complement sample from the ADC PHY
//   adc_valid      adc_data_i carries a sample this cycle
//   adc_ready      ADC SPI init complete; dropping it aborts a capture
//   arm            start request (honoured in IDLE and DONE only)
//   trig_en        0 = start on first valid sample, 1 = level trigger
//   trig_level     signed trigger threshold
//   rd_addr/rd_en  read request, one cycle latency
//   rd_data        read data, holds its last value when rd_en is low
//   rd_valid       rd_data was loaded on the previous edge
//   busy           ARMED or CAPTURE
//   capture_done   a full record is stored
//   capture_abort  one-cycle pulse when adc_ready drops mid-capture
//   wr_count       samples written in the current record
// -----------------------------------------------------------------------------
module syzygy_adc_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     adc_data_i,
  input  logic                  adc_valid,
  input  logic                  adc_ready,
  input  logic                  arm,
  input  logic                  trig_en,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  capture_done,
  output logic                  capture_abort,
  output logic [DEPTH_LOG2:0]   wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2:0]     wr_count_q, wr_count_d;
  logic [DATA_W-1:0]       prev_q, prev_d;
  logic                    prev_valid_q, prev_valid_d;
  logic                    abort_q, abort_d;
  logic                    we;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic                    trig_hit;

  logic [DATA_W-1:0]       mem [DEPTH];

  // Rising crossing: previous sample strictly below the threshold, current at
  // or above it. prev_valid_q keeps the first sample after arm from firing.
  assign trig_hit = prev_valid_q
                 && ($signed(prev_q) < $signed(trig_level))
                 && ($signed(adc_data_i) >= $signed(trig_level));

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    wr_count_d   = wr_count_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    abort_d      = 1'b0;
    we           = 1'b0;
    wr_addr      = wr_count_q[DEPTH_LOG2-1:0];

    unique case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d      = ARMED;
          wr_count_d   = '0;
          prev_valid_d = 1'b0;
        end
      end

      ARMED: begin
        if (!adc_ready) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (adc_valid) begin
          prev_d       = adc_data_i;
          prev_valid_d = 1'b1;
          if (!trig_en || trig_hit) begin
            we         = 1'b1;
            wr_addr    = '0;
            wr_count_d = (DEPTH_LOG2+1)'(1);
            state_d    = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        // Abort takes priority over a write, including the final one.
        if (!adc_ready) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (adc_valid) begin
          we         = 1'b1;
          wr_count_d = wr_count_q + (DEPTH_LOG2+1)'(1);
          if (wr_count_q == (DEPTH_LOG2+1)'(DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_count_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_count_q   <= wr_count_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      abort_q      <= abort_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Record RAM
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array has no reset so it maps onto block RAM; contents are
  // undefined until the first capture writes them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= adc_data_i;
    end
  end

  // Registered read port. Reading mem here with a non-blocking update gives
  // read-first behaviour on a same-address collision with the write above.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

  assign busy          = (state_q == ARMED) || (state_q == CAPTURE);
  assign capture_done  = (state_q == DONE);
  assign capture_abort = abort_q;
  assign wr_count      = wr_count_q;

endmodule
